// File: rtl/oclib_bc_csr_pkg.sv
// Shared definitions for the CSR byte-channel responder: request command
// codes, response status codes and the responder state encoding.
package oclib_bc_csr_pkg;

    localparam logic [7:0] CmdRead       = 8'h01;
    localparam logic [7:0] CmdWrite      = 8'h02;

    localparam logic [7:0] StatusOk      = 8'h00;
    localparam logic [7:0] StatusTimeout = 8'h01;
    localparam logic [7:0] StatusBadCmd  = 8'h02;

    typedef enum logic [2:0] {
        StCmd,
        StAddr,
        StWdata,
        StAccess,
        StRstat,
        StRdata
    } state_e;

endpackage

// File: rtl/oclib_bc_word_shifter.sv
// 32-bit MSB-first byte shifter with a 2-bit byte counter.
// Used both to assemble incoming words and to emit outgoing words.
// Ports:
//   clock, reset      rising-edge clock, synchronous active-low reset
//   i_load/i_loadData parallel load (also clears the byte counter)
//   i_shift/i_byteIn  shift word left by one byte, i_byteIn enters at LSB
//   o_word            current word; o_word[31:24] is the next byte out
//   o_last            the counter is on the 4th byte of the word
module oclib_bc_word_shifter (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_load,
    input  logic [31:0] i_loadData,
    input  logic        i_shift,
    input  logic [7:0]  i_byteIn,
    output logic [31:0] o_word,
    output logic        o_last
);

    logic [31:0] r_word;
    logic [1:0]  r_count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_word  <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_word  <= i_loadData;
            r_count <= '0;
        end else if (i_shift) begin
            r_word  <= {r_word[23:0], i_byteIn};
            r_count <= r_count + 2'd1;
        end
    end

    assign o_word = r_word;
    assign o_last = (r_count == 2'd3);

endmodule

// File: rtl/oclib_bc_csr_responder.sv
// Leaf-side CSR byte-channel responder. Collects one request frame
// (cmd, 4 address bytes, 4 write-data bytes for writes), performs one local
// register access, then returns a status byte plus 4 read-data bytes for
// successful reads.
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-low reset
//   inData/inValid/inReady       request byte channel
//   outData/outValid/outReady    response byte channel
//   csrRead/csrWrite             access strobes, held for the whole access
//   csrAddress/csrWdata          access address / write data (held until next request)
//   csrRdata/csrReady            read data and one-cycle ack from registers
module oclib_bc_csr_responder
    import oclib_bc_csr_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned BlockId       = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  inData,
    input  logic        inValid,
    output logic        inReady,
    output logic [7:0]  outData,
    output logic        outValid,
    input  logic        outReady,
    output logic        csrRead,
    output logic        csrWrite,
    output logic [31:0] csrAddress,
    output logic [31:0] csrWdata,
    input  logic [31:0] csrRdata,
    input  logic        csrReady
);

    localparam int unsigned     TmoW    = $clog2(TimeoutCycles + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

    state_e          r_state;
    state_e          w_next;
    logic            r_isWrite;
    logic [7:0]      r_status;
    logic            r_armed;
    logic [TmoW-1:0] r_tmo;
    logic [31:0]     r_csrAddress;
    logic [31:0]     r_csrWdata;

    logic        w_inReady;
    logic        w_outValid;
    logic [7:0]  w_outData;
    logic        w_inXfer;
    logic        w_outXfer;
    logic        w_validCmd;
    logic        w_tmoHit;
    logic        w_accessDone;
    logic        w_rxLoad;
    logic        w_rxShift;
    logic        w_txLoad;
    logic        w_txShift;
    logic [31:0] w_rxWord;
    logic [31:0] w_txWord;
    logic        w_rxLast;
    logic        w_txLast;
    logic        w_unused;

    assign w_inXfer     = inValid & w_inReady;
    assign w_outXfer    = w_outValid & outReady;
    assign w_validCmd   = (inData == CmdRead) || (inData == CmdWrite);
    assign w_tmoHit     = (r_tmo == TmoLast);
    // csrReady takes priority over a simultaneous timeout expiry.
    assign w_accessDone = csrReady | w_tmoHit;

    oclib_bc_word_shifter u_rx (
        .clock      (clock),
        .reset      (reset),
        .i_load     (w_rxLoad),
        .i_loadData ('0),
        .i_shift    (w_rxShift),
        .i_byteIn   (inData),
        .o_word     (w_rxWord),
        .o_last     (w_rxLast)
    );

    oclib_bc_word_shifter u_tx (
        .clock      (clock),
        .reset      (reset),
        .i_load     (w_txLoad),
        .i_loadData (csrReady ? csrRdata : 32'h0),
        .i_shift    (w_txShift),
        .i_byteIn   (8'h00),
        .o_word     (w_txWord),
        .o_last     (w_txLast)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= StCmd;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_inReady  = 1'b0;
        w_outValid = 1'b0;
        w_outData  = r_status;
        csrRead    = 1'b0;
        csrWrite   = 1'b0;
        w_rxLoad   = 1'b0;
        w_rxShift  = 1'b0;
        w_txLoad   = 1'b0;
        w_txShift  = 1'b0;
        case (r_state)
            StCmd: begin
                // inReady is gated by reset so nothing is accepted in a reset cycle.
                w_inReady = reset;
                w_rxLoad  = 1'b1;
                if (w_inXfer) begin
                    w_next = w_validCmd ? StAddr : StRstat;
                end
            end
            StAddr: begin
                w_inReady = reset;
                w_rxShift = w_inXfer;
                if (w_inXfer && w_rxLast) begin
                    w_next = r_isWrite ? StWdata : StAccess;
                end
            end
            StWdata: begin
                w_inReady = reset;
                w_rxShift = w_inXfer;
                if (w_inXfer && w_rxLast) begin
                    w_next = StAccess;
                end
            end
            StAccess: begin
                csrRead  = !r_isWrite;
                csrWrite = r_isWrite;
                if (w_accessDone) begin
                    w_txLoad = 1'b1;
                    w_next   = StRstat;
                end
            end
            StRstat: begin
                // First RSTAT cycle stages the response; the status byte
                // is offered from the second cycle on.
                w_outValid = r_armed;
                w_outData  = r_status;
                if (w_outXfer) begin
                    w_next = (!r_isWrite && r_status == StatusOk) ? StRdata : StCmd;
                end
            end
            StRdata: begin
                w_outValid = 1'b1;
                w_outData  = w_txWord[31:24];
                w_txShift  = w_outXfer;
                if (w_outXfer && w_txLast) begin
                    w_next = StCmd;
                end
            end
            default: begin
                w_next = StCmd;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_isWrite    <= 1'b0;
            r_status     <= StatusOk;
            r_armed      <= 1'b0;
            r_tmo        <= '0;
            r_csrAddress <= '0;
            r_csrWdata   <= '0;
        end else begin
            // Entry into RSTAT always comes from a different state, so this
            // is low exactly for the first RSTAT cycle.
            r_armed <= (r_state == StRstat);
            r_tmo   <= (r_state == StAccess) ? r_tmo + TmoW'(1) : '0;
            if (r_state == StCmd && w_inXfer) begin
                r_isWrite <= (inData == CmdWrite);
                r_status  <= w_validCmd ? StatusOk : StatusBadCmd;
            end
            if (r_state == StAddr && w_inXfer && w_rxLast) begin
                r_csrAddress <= {w_rxWord[23:0], inData};
            end
            if (r_state == StWdata && w_inXfer && w_rxLast) begin
                r_csrWdata <= {w_rxWord[23:0], inData};
            end
            if (r_state == StAccess && w_accessDone) begin
                r_status <= csrReady ? StatusOk : StatusTimeout;
            end
        end
    end

    assign inReady    = w_inReady;
    assign outValid   = w_outValid;
    assign outData    = w_outData;
    assign csrAddress = r_csrAddress;
    assign csrWdata   = r_csrWdata;

    // BlockId is reserved and carries no function.
    assign w_unused = ^{w_rxWord[31:24], w_txWord[23:0], BlockId[7:0]};

endmodule

// File: tb/tb_oclib_bc_csr_responder.sv
module tb_oclib_bc_csr_responder;

    logic        clock;
    logic        reset;
    logic [7:0]  inData;
    logic        inValid;
    logic        inReady;
    logic [7:0]  outData;
    logic        outValid;
    logic        outReady;
    logic        csrRead;
    logic        csrWrite;
    logic [31:0] csrAddress;
    logic [31:0] csrWdata;
    logic [31:0] csrRdata;
    logic        csrReady;

    int n_checks = 0;
    int n_fail   = 0;

    oclib_bc_csr_responder #(
        .TimeoutCycles (16),
        .BlockId       (0)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .inData     (inData),
        .inValid    (inValid),
        .inReady    (inReady),
        .outData    (outData),
        .outValid   (outValid),
        .outReady   (outReady),
        .csrRead    (csrRead),
        .csrWrite   (csrWrite),
        .csrAddress (csrAddress),
        .csrWdata   (csrWdata),
        .csrRdata   (csrRdata),
        .csrReady   (csrReady)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Offer one request byte until accepted; returns 1ns after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        inData  = b;
        inValid = 1'b1;
        #1;
        while (!inReady && n < 100) begin
            @(posedge clock);
            #2;
            n++;
        end
        check("inReady_wait", 32'(n < 100), 1);
        step();
        inValid = 1'b0;
        inData  = 8'h00;
    endtask

    task automatic send_req(input logic [7:0] cmd, input logic [31:0] addr,
                            input logic [31:0] wd, input bit gaps);
        logic [7:0] b;
        send_byte(cmd);
        for (int i = 3; i >= 0; i--) begin
            if (gaps) step();
            b = addr[i*8 +: 8];
            send_byte(b);
        end
        if (cmd == 8'h02) begin
            for (int i = 3; i >= 0; i--) begin
                if (gaps) step();
                b = wd[i*8 +: 8];
                send_byte(b);
            end
        end
    endtask

    // Wait for a response byte and compare it; optionally stall one cycle
    // with outReady low first and verify the byte is held.
    task automatic recv_byte(input string tag, input logic [7:0] exp, input bit stall);
        int n;
        n = 0;
        outReady = 1'b0;
        #1;
        while (!outValid && n < 100) begin
            @(posedge clock);
            #2;
            n++;
        end
        check({tag, "_wait"}, 32'(n < 100), 1);
        if (stall) begin
            @(posedge clock);
            #2;
            check({tag, "_held_valid"}, 32'(outValid), 1);
            check({tag, "_held_data"}, 32'(outData), 32'(exp));
        end
        check(tag, 32'(outData), 32'(exp));
        outReady = 1'b1;
        step();
        outReady = 1'b0;
    endtask

    // Ack a read in the first ACCESS cycle (called 1ns into that cycle).
    task automatic ack_read(input string tag, input logic [31:0] addr, input logic [31:0] rd);
        csrRdata = rd;
        csrReady = 1'b1;
        #1;
        check({tag, "_csrRead"}, 32'(csrRead), 1);
        check({tag, "_csrWrite"}, 32'(csrWrite), 0);
        check({tag, "_addr"}, csrAddress, addr);
        step();
        csrReady = 1'b0;
        csrRdata = 32'h0;
        #1;
        check({tag, "_csrRead_drop"}, 32'(csrRead), 0);
    endtask

    task automatic recv_word(input string tag, input logic [31:0] w, input bit stall);
        logic [7:0] b;
        for (int i = 3; i >= 0; i--) begin
            b = w[i*8 +: 8];
            recv_byte($sformatf("%s_b%0d", tag, 3 - i), b, stall);
        end
    endtask

    initial begin
        int cnt;
        bit seen;
        reset    = 1'b0;
        inData   = 8'h00;
        inValid  = 1'b0;
        outReady = 1'b0;
        csrRdata = 32'h0;
        csrReady = 1'b0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        inValid = 1'b1;
        #1;
        check("rst_inReady", 32'(inReady), 0);
        check("rst_outValid", 32'(outValid), 0);
        check("rst_strobes", {30'h0, csrRead, csrWrite}, 0);
        check("rst_addr", csrAddress, 32'h0);
        check("rst_wdata", csrWdata, 32'h0);
        inValid = 1'b0;
        reset   = 1'b1;
        #1;
        check("idle_inReady", 32'(inReady), 1);

        // csrReady outside ACCESS is ignored
        step();
        csrReady = 1'b1;
        csrRdata = 32'hFFFF_FFFF;
        step();
        csrReady = 1'b0;
        repeat (3) step();
        check("stray_ready_outValid", 32'(outValid), 0);
        check("stray_ready_inReady", 32'(inReady), 1);

        // Write, ack 2 cycles after the first ACCESS cycle
        send_req(8'h02, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        #1;
        check("wr_csrWrite", 32'(csrWrite), 1);
        check("wr_csrRead", 32'(csrRead), 0);
        check("wr_addr", csrAddress, 32'h0000_0010);
        check("wr_wdata", csrWdata, 32'hDEAD_BEEF);
        check("wr_inReady", 32'(inReady), 0);
        step();
        step();
        check("wr_csrWrite_held", 32'(csrWrite), 1);
        csrReady = 1'b1;
        step();
        csrReady = 1'b0;
        #1;
        check("wr_csrWrite_drop", 32'(csrWrite), 0);
        recv_byte("wr_status", 8'h00, 1'b0);
        #1;
        check("wr_back_to_cmd", 32'(inReady), 1);
        check("wr_addr_hold", csrAddress, 32'h0000_0010);

        // Minimum latency: ack in first ACCESS cycle -> status valid 3 cycles after last byte
        send_req(8'h02, 32'h0000_0014, 32'h0102_0304, 1'b0);
        csrReady = 1'b1;
        #1;
        check("lat_csrWrite", 32'(csrWrite), 1);
        step();
        csrReady = 1'b0;
        #1;
        check("lat_n2_outValid", 32'(outValid), 0);
        check("lat_n2_strobe", 32'(csrWrite), 0);
        step();
        #1;
        check("lat_n3_outValid", 32'(outValid), 1);
        check("lat_n3_outData", 32'(outData), 32'h00);
        recv_byte("lat_status", 8'h00, 1'b0);

        // Read
        send_req(8'h01, 32'h0000_0020, 32'h0, 1'b0);
        ack_read("rd", 32'h0000_0020, 32'h1234_5678);
        recv_byte("rd_status", 8'h00, 1'b0);
        recv_word("rd_data", 32'h1234_5678, 1'b0);
        #1;
        check("rd_back_to_cmd", 32'(inReady), 1);
        check("rd_wdata_hold", csrWdata, 32'h0102_0304);

        // Timeout: csrRead high exactly 16 cycles, status 01 only
        send_req(8'h01, 32'h0000_0020, 32'h0, 1'b0);
        #1;
        cnt = 0;
        while (csrRead && cnt < 100) begin
            cnt++;
            @(posedge clock);
            #2;
        end
        check("tmo_read_cycles", 32'(cnt), 16);
        recv_byte("tmo_status", 8'h01, 1'b0);
        seen = 1'b0;
        outReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (outValid) seen = 1'b1;
            step();
        end
        outReady = 1'b0;
        check("tmo_no_data", 32'(seen), 0);
        check("tmo_back_to_cmd", 32'(inReady), 1);

        // Bad command, then a normal read
        send_byte(8'h7F);
        #1;
        check("bad_inReady", 32'(inReady), 0);
        recv_byte("bad_status", 8'h02, 1'b0);
        send_req(8'h01, 32'h0000_0004, 32'h0, 1'b0);
        ack_read("bad_rd", 32'h0000_0004, 32'hA5A5_0004);
        recv_byte("bad_rd_status", 8'h00, 1'b0);
        recv_word("bad_rd_data", 32'hA5A5_0004, 1'b0);

        // Backpressure: gapped request, outReady toggled on the response
        send_req(8'h01, 32'h0000_0030, 32'h0, 1'b1);
        ack_read("bp", 32'h0000_0030, 32'h0BAD_CAFE);
        recv_byte("bp_status", 8'h00, 1'b1);
        recv_word("bp_data", 32'h0BAD_CAFE, 1'b1);
        #1;
        check("bp_back_to_cmd", 32'(inReady), 1);

        // Reset after 3rd address byte
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        reset = 1'b0;
        #1;
        check("mid_rst_inReady", 32'(inReady), 0);
        step();
        reset = 1'b1;
        #1;
        check("mid_rst_strobes", {30'h0, csrRead, csrWrite}, 0);
        check("mid_rst_addr", csrAddress, 32'h0);
        check("mid_rst_inReady_after", 32'(inReady), 1);
        seen = 1'b0;
        outReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (outValid || csrRead || csrWrite) seen = 1'b1;
            step();
            #1;
        end
        outReady = 1'b0;
        check("mid_rst_silent", 32'(seen), 0);
        send_req(8'h01, 32'h0000_0008, 32'h0, 1'b0);
        ack_read("post_rst", 32'h0000_0008, 32'hCAFE_F00D);
        recv_byte("post_rst_status", 8'h00, 1'b0);
        recv_word("post_rst_data", 32'hCAFE_F00D, 1'b0);

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected completion");
        $fatal(1);
    end

endmodule
